crt_regfile: RTL and testbench
==============================

CRT_REGFILE -- requirements
Module: crt_regfile

Interface
REQ-001 Parameter WIDTH, default 16, bit width of every register.
REQ-002 Parameter DEPTH, default 16, number of registers (2..256).
REQ-003 Parameter ADDR_W, default 8, address width; 2**ADDR_W >= DEPTH.
REQ-004 Parameter RESET_VALUES, default all zero, DEPTH*WIDTH bits; register i reset value is bits [i*WIDTH +: WIDTH].
REQ-005 Parameter IMMEDIATE_MASK, default 0, DEPTH bits; bit i set means register i bypasses the shadow stage.
REQ-006 Parameter LOCK_MASK, default 0, DEPTH bits; bit i set means register i is write-protected while lock is high.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-009 cs  input  1  bus select; access occurs in any cycle with cs high.
REQ-010 we  input  1  1 = write, 0 = read; sampled only with cs.
REQ-011 addr  input  ADDR_W  register index.
REQ-012 wdata  input  WIDTH  write data.
REQ-013 rdata  output  WIDTH  registered read data.
REQ-014 rvalid  output  1  one-cycle pulse qualifying rdata.
REQ-015 commit  input  1  frame-boundary strobe (vsync), single-cycle pulse.
REQ-016 lock  input  1  write protect for LOCK_MASK registers.
REQ-017 value  output  DEPTH*WIDTH  active register contents, register i at [i*WIDTH +: WIDTH].
REQ-018 pending  output  DEPTH  bit i high = shadow i written, not yet committed.
REQ-019 err  output  1  one-cycle pulse on a rejected write.

Function
REQ-020 Each register holds a shadow word, an active word and a pending bit; value drives the active words.
REQ-021 Accepted write (cs & we, addr < DEPTH, not locked) loads shadow[addr] <= wdata on the next edge.
REQ-022 Non-immediate register: an accepted write also sets pending[addr]; active is unchanged until commit.
REQ-023 Immediate register: an accepted write loads shadow and active in the same edge; pending stays 0.
REQ-024 On a commit cycle, every register with pending set copies shadow to active and clears pending, all in one edge.
REQ-025 Write and commit in the same cycle: commit copies the pre-write shadow; the write loads shadow and leaves pending set.
REQ-026 Write rejected when addr >= DEPTH, or when lock is high and LOCK_MASK[addr] is set; no state changes; err pulses in the next cycle.
REQ-027 Read (cs & ~we): rdata <= shadow[addr] and rvalid <= 1 at the next edge; latency exactly 1 cycle.
REQ-028 Read with addr >= DEPTH returns 0 with rvalid 1 and no err.
REQ-029 rdata holds its last value while rvalid is 0; rvalid and err are never high for more than one cycle per access.
REQ-030 Back-to-back accesses are accepted every cycle with no stall; no ready signal exists.
REQ-031 Commit with no pending bits set has no effect.

Reset
REQ-032 While reset_n is low: shadow and active of register i = RESET_VALUES slice i, pending = 0, rdata = 0, rvalid = 0, err = 0.
REQ-033 Reset asserts asynchronously and overrides any write, read or commit in progress; after release, the first rising edge with cs high is serviced normally.

Structure
REQ-034 Shared package crt_pkg holds default WIDTH/DEPTH constants and CRT register index constants (horizontal total, display end, sync start/end, vertical equivalents, start address, cursor).
REQ-035 One sub-module crt_regfile_cell implements a single shadow/active/pending register; crt_regfile instantiates DEPTH cells via generate and owns decode, lock check, read mux and err.

Verification
REQ-036 Reset, RESET_VALUES reg2 = 0x0050 -> value slice 2 = 0x0050, pending = 0, rdata = 0 before any access.
REQ-037 Write reg3 = 0x1234, read reg3 -> rdata 0x1234, rvalid one cycle later, value slice 3 unchanged, pending[3] = 1; commit pulse -> slice 3 = 0x1234, pending[3] = 0.
REQ-038 IMMEDIATE_MASK bit 5 set, write reg5 = 0x00AA -> value slice 5 = 0x00AA next edge, pending[5] = 0.
REQ-039 Write reg1 = 0x0001, then write reg1 = 0x0002 in the same cycle as commit -> active 0x0001, shadow 0x0002, pending[1] = 1.
REQ-040 LOCK_MASK bit 0 set, lock = 1, write reg0 = 0xFFFF -> err pulse, reg0 unchanged; write to addr = DEPTH -> err pulse; read addr = DEPTH -> rdata 0, rvalid 1.
REQ-041 reset_n low mid-stream after writes and commits -> all outputs return to REQ-032 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/crt_pkg.sv
// crt_pkg: shared defaults and CRT register indices for the CRT register file.
// Contents:
//   CRT_WIDTH / CRT_DEPTH  default register width and count
//   crt_reg_e              index of each CRT timing/address register
package crt_pkg;

    localparam int CRT_WIDTH  = 16;
    localparam int CRT_DEPTH  = 16;
    localparam int CRT_ADDR_W = 8;

    typedef enum logic [7:0] {
        CRT_H_TOTAL      = 8'd0,
        CRT_H_DISP_END   = 8'd1,
        CRT_H_SYNC_START = 8'd2,
        CRT_H_SYNC_END   = 8'd3,
        CRT_V_TOTAL      = 8'd4,
        CRT_V_DISP_END   = 8'd5,
        CRT_V_SYNC_START = 8'd6,
        CRT_V_SYNC_END   = 8'd7,
        CRT_START_ADDR   = 8'd8,
        CRT_CURSOR       = 8'd9
    } crt_reg_e;

endpackage

// File: rtl/crt_regfile_cell.sv
// crt_regfile_cell: one shadow/active/pending register.
// Ports:
//   clk, reset_n  clock and async active-low reset
//   wr_en_i       accepted write to this register
//   wdata_i       write data
//   commit_i      frame-boundary strobe: pending shadow moves to active
//   shadow_o      shadow word (read-back value)
//   active_o      active word (drives the display timing)
//   pending_o     shadow written but not yet committed
module crt_regfile_cell
    import crt_pkg::*;
#(
    parameter int               WIDTH     = CRT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               IMMEDIATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             commit_i,
    output logic [WIDTH-1:0] shadow_o,
    output logic [WIDTH-1:0] active_o,
    output logic             pending_o
);

    logic [WIDTH-1:0] shadow_q, shadow_d, active_q, active_d;
    logic             pending_q, pending_d;

    // Commit copies the pre-edge shadow, so a same-cycle write lands only in
    // shadow and re-arms pending for the next frame.
    always_comb begin
        shadow_d  = wr_en_i ? wdata_i : shadow_q;
        active_d  = (IMMEDIATE && wr_en_i) ? wdata_i :
                    (commit_i && pending_q) ? shadow_q : active_q;
        pending_d = IMMEDIATE ? 1'b0 : wr_en_i ? 1'b1 : commit_i ? 1'b0 : pending_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q  <= RESET_VAL;
            active_q  <= RESET_VAL;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign shadow_o  = shadow_q;
    assign active_o  = active_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/crt_regfile.sv
// crt_regfile: double-buffered CRT register file with frame-boundary commit.
// Ports:
//   clk, reset_n   clock and async active-low reset
//   cs, we, addr   bus access select, direction, register index
//   wdata / rdata  write data / registered read data (rvalid qualifies)
//   commit         vsync strobe: pending shadows become active
//   lock           write protect for LOCK_MASK registers
//   value          active words, register i at [i*WIDTH +: WIDTH]
//   pending        per-register uncommitted-write flags
//   err            one-cycle pulse after a rejected write
module crt_regfile
    import crt_pkg::*;
#(
    parameter int                     WIDTH          = CRT_WIDTH,
    parameter int                     DEPTH          = CRT_DEPTH,
    parameter int                     ADDR_W         = CRT_ADDR_W,
    parameter logic [DEPTH*WIDTH-1:0] RESET_VALUES   = '0,
    parameter logic [DEPTH-1:0]       IMMEDIATE_MASK = '0,
    parameter logic [DEPTH-1:0]       LOCK_MASK      = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cs,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rvalid,
    input  logic                   commit,
    input  logic                   lock,
    output logic [DEPTH*WIDTH-1:0] value,
    output logic [DEPTH-1:0]       pending,
    output logic                   err
);

    logic [DEPTH-1:0] wr_sel;
    logic [WIDTH-1:0] shadow [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d, rd_mux;
    logic             rvalid_q, err_q, err_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        assign wr_sel[i] = cs && we && (addr == ADDR_W'(i)) && !(lock && LOCK_MASK[i]);
        crt_regfile_cell #(
            .WIDTH    (WIDTH),
            .RESET_VAL(RESET_VALUES[i*WIDTH +: WIDTH]),
            .IMMEDIATE(IMMEDIATE_MASK[i])
        ) u_cell (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr_en_i  (wr_sel[i]),
            .wdata_i  (wdata),
            .commit_i (commit),
            .shadow_o (shadow[i]),
            .active_o (value[i*WIDTH +: WIDTH]),
            .pending_o(pending[i])
        );
    end

    // Out-of-range reads fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int j = 0; j < DEPTH; j++)
            if (addr == ADDR_W'(j)) rd_mux = shadow[j];
    end

    // A write that selected no cell was out of range or locked.
    always_comb begin
        rdata_d = (cs && !we) ? rd_mux : rdata_q;
        err_d   = cs && we && (wr_sel == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= cs && !we;
            err_q    <= err_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_crt_regfile.sv
// tb_crt_regfile: randomized scoreboard bench for crt_regfile against a behavioural model.
module tb_crt_regfile;

    localparam int W = 16;
    localparam int D = 16;
    localparam int AW = 8;
    localparam logic [D*W-1:0] RV = {
        16'hF00F, 16'hE00E, 16'hD00D, 16'hC00C, 16'hB00B, 16'hA00A, 16'h9009, 16'h8008,
        16'h7007, 16'h6006, 16'h5005, 16'h4004, 16'h3003, 16'h0050, 16'h0011, 16'h5A5A};
    localparam logic [D-1:0] IMM = 16'h0220;
    localparam logic [D-1:0] LCK = 16'h0101;

    logic clk = 0, reset_n = 0, cs = 0, we = 0, commit = 0, lock = 0;
    logic [AW-1:0] addr = '0;
    logic [W-1:0] wdata = '0, rdata;
    logic rvalid, err;
    logic [D*W-1:0] value;
    logic [D-1:0] pending;

    crt_regfile #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .RESET_VALUES(RV),
                  .IMMEDIATE_MASK(IMM), .LOCK_MASK(LCK)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .commit(commit), .lock(lock),
        .value(value), .pending(pending), .err(err));

    always #5 clk = ~clk;

    typedef struct { bit is_err; logic [W-1:0] data; } resp_t;
    resp_t q[$];
    int tests = 0, fails = 0;
    logic [W-1:0] last_rd = '0;
    logic [W-1:0] rv_w [D];
    logic [W-1:0] sh [D];
    logic [W-1:0] act [D];
    logic [D-1:0] pend;
    logic [D-1:0] imm_m = IMM, lck_m = LCK;

    task automatic chk(input string nm, input logic [D*W-1:0] got, input logic [D*W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [D*W-1:0] model_value();
        logic [D*W-1:0] v;
        for (int i = 0; i < D; i++) v[i*W +: W] = act[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            rv_w[i] = RV[i*W +: W];
            sh[i] = rv_w[i];
            act[i] = rv_w[i];
        end
        pend = '0;
        last_rd = '0;
    endtask

    // One bus cycle: drive inputs, predict responses, step the model across the edge.
    task automatic cyc(input bit c, input bit w, input int a, input logic [W-1:0] d,
                       input bit cm, input bit lk);
        bit in_range, ok;
        cs = c; we = w; addr = AW'(a); wdata = d; commit = cm; lock = lk;
        in_range = a < D;
        ok = c && w && in_range && !(lk && lck_m[in_range ? a : 0]);
        if (c && !w) q.push_back('{0, in_range ? sh[a] : '0});
        if (c && w && !ok) q.push_back('{1, '0});
        if (cm)
            for (int i = 0; i < D; i++)
                if (pend[i]) begin act[i] = sh[i]; pend[i] = 0; end
        if (ok) begin
            sh[a] = d;
            if (imm_m[a]) act[a] = d; else pend[a] = 1;
        end
        @(posedge clk); #1;
        cs = 0; we = 0; commit = 0; lock = 0;
        chk("value", value, model_value());
        chk("pending", {{(D*W-D){1'b0}}, pending}, {{(D*W-D){1'b0}}, pend});
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (rvalid || err) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL resp: got rvalid=%b err=%b with nothing expected", rvalid, err);
                end else begin
                    resp_t e;
                    e = q.pop_front();
                    chk("resp", {err, rvalid, err ? '0 : rdata},
                        {e.is_err, !e.is_err, e.is_err ? '0 : e.data});
                    if (!e.is_err) last_rd = e.data;
                end
            end else chk("rdata_hold", rdata, last_rd);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_slice2", value[2*W +: W], 16'h0050);
        chk("rst_value", value, RV);
        chk("rst_pending", pending, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        reset_n = 1;
        cyc(1, 1, 3, 16'h1234, 0, 0);
        cyc(1, 0, 3, 0, 0, 0);
        chk("w3_active", value[3*W +: W], 16'h3003);
        chk("w3_pend", pending[3], 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("c3_active", value[3*W +: W], 16'h1234);
        chk("c3_pend", pending[3], 0);
        cyc(1, 1, 5, 16'h00AA, 0, 0);
        chk("imm5", value[5*W +: W], 16'h00AA);
        chk("imm5_pend", pending[5], 0);
        cyc(1, 1, 1, 16'h0001, 0, 0);
        cyc(1, 1, 1, 16'h0002, 1, 0);
        chk("wc1_active", value[1*W +: W], 16'h0001);
        chk("wc1_pend", pending[1], 1);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 16'hFFFF, 0, 1);
        chk("lock0", value[W-1:0], 16'h5A5A);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, D, 16'h7777, 0, 0);
        cyc(1, 0, D, 0, 0, 0);
        cyc(1, 1, 0, 16'hBEEF, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 20),
                W'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 1));
        cyc(1, 1, 7, 16'hCAFE, 0, 0);
        cyc(1, 1, 9, 16'h1111, 0, 0);
        @(negedge clk); #1;
        reset_n = 0;
        #1;
        model_reset();
        chk("arst_value", value, RV);
        chk("arst_pending", pending, 0);
        chk("arst_rdata", rdata, 0);
        chk("arst_flags", {rvalid, err}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        cyc(1, 0, 2, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("queue_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
